// File: rtl/step_ctrl_pkg.sv
// Shared types and sizing helpers for the step controller slice.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2
    } step_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus hold-time debounce; emits a one-cycle press on each accepted rising level.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    // Synchronise, count consecutive disagreeing cycles, and register the rising edge of the stable level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    assign level = r_stable;
    assign press = r_press;

endmodule

// File: rtl/step_ctrl.sv
// CPU step/reset front end: debounced buttons, manual step, fixed-rate auto-run and stretched CPU reset.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000,
    parameter int RST_CYCLES      = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             btn_reset,
    input  logic             sw_run,
    output logic             cpu_step,
    output logic             cpu_reset,
    output logic             run_active,
    output logic [CNT_W-1:0] step_count
);

    localparam int                DIV_W     = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam int                HOLD_W    = cnt_width(RST_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    logic w_step_press;
    logic w_rst_press;
    logic w_step_level;
    logic w_rst_level;
    logic w_unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_step),
        .level (w_step_level),
        .press (w_step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_reset),
        .level (w_rst_level),
        .press (w_rst_press)
    );

    // Debounced levels are kept for probing; the FSM only reacts to presses.
    assign w_unused_levels = w_step_level ^ w_rst_level;

    logic              r_run_s1;
    logic              r_run_s2;
    step_state_t       r_state;
    step_state_t       w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_step_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_cpu_step;
    logic              r_cpu_reset;
    logic              r_run_active;

    // Next-state logic; reset press overrides every other event in every state.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_hold_next  = r_hold;
        w_step_next  = 1'b0;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_rst_press) begin
                    w_state_next = S_RST;
                    w_hold_next  = '0;
                end else if (r_run_s2) begin
                    w_state_next = S_RUN;
                    w_div_next   = '0;
                end else if (w_step_press) begin
                    w_step_next = 1'b1;
                end else begin
                    w_step_next = 1'b0;
                end
            end
            S_RUN: begin
                if (w_rst_press) begin
                    w_state_next = S_RST;
                    w_hold_next  = '0;
                    w_div_next   = '0;
                end else if (!r_run_s2) begin
                    w_state_next = S_IDLE;
                    w_div_next   = '0;
                end else if (r_div == DIV_LAST) begin
                    w_div_next  = '0;
                    w_step_next = 1'b1;
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            S_RST: begin
                if (w_rst_press) begin
                    w_hold_next = '0;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_next = S_IDLE;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The last hold cycle carries a step so the CPU's synchronous reset gets clocked.
        if ((w_state_next == S_RST) && (w_hold_next == HOLD_LAST)) begin
            w_step_next = 1'b1;
        end else begin
            w_step_next = w_step_next;
        end

        if (w_state_next == S_RST) begin
            w_count_next = '0;
        end else if (w_step_next) begin
            w_count_next = r_count + CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_s1     <= 1'b0;
            r_run_s2     <= 1'b0;
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_hold       <= '0;
            r_count      <= '0;
            r_cpu_step   <= 1'b0;
            r_cpu_reset  <= 1'b0;
            r_run_active <= 1'b0;
        end else begin
            r_run_s1     <= sw_run;
            r_run_s2     <= r_run_s1;
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_hold       <= w_hold_next;
            r_count      <= w_count_next;
            r_cpu_step   <= w_step_next;
            r_cpu_reset  <= (w_state_next == S_RST);
            r_run_active <= (w_state_next == S_RUN);
        end
    end

    assign cpu_step   = r_cpu_step;
    assign cpu_reset  = r_cpu_reset;
    assign run_active = r_run_active;
    assign step_count = r_count;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: expected cpu_step pulses are queued by the stimulus and checked by a monitor.
module tb_step_ctrl;
    import step_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_step = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_run = 1'b0;
    logic       cpu_step;
    logic       cpu_reset;
    logic       run_active;
    logic [3:0] step_count;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       rst;
        logic       run;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (8),
        .RST_CYCLES     (3),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_step   (btn_step),
        .btn_reset  (btn_reset),
        .sw_run     (sw_run),
        .cpu_step   (cpu_step),
        .cpu_reset  (cpu_reset),
        .run_active (run_active),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic r, input logic run, input int cnt);
        exp_t e;
        e.cyc = c;
        e.rst = r;
        e.run = run;
        e.cnt = 4'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cpu_step pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cpu_step === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cpu_reset", int'(cpu_reset), int'(e.rst));
                check("pulse_run_active", int'(run_active), int'(e.run));
                check("pulse_step_count", int'(step_count), int'(e.cnt));
            end
        end
    end

    initial begin
        int t;
        int rexp[5];

        // Reset state
        wait_n(3);
        check("rst_cpu_step", int'(cpu_step), 0);
        check("rst_cpu_reset", int'(cpu_reset), 0);
        check("rst_run_active", int'(run_active), 0);
        check("rst_step_count", int'(step_count), 0);
        reset = 1'b0;

        // 1: single clean press -> one pulse at t0+8
        t = cyc;
        btn_step = 1'b1;
        expect_pulse(t + 8, 1'b0, 1'b0, 1);
        wait_n(10);
        btn_step = 1'b0;
        wait_n(20);

        // 2: short glitch and chatter -> nothing
        btn_step = 1'b1;
        wait_n(3);
        btn_step = 1'b0;
        wait_n(10);
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            wait_n(2);
        end
        btn_step = 1'b0;
        wait_n(20);

        // 3: auto-run, mid-run step press ignored, no pulse on exit at the tick boundary
        t = cyc;
        sw_run = 1'b1;
        expect_pulse(t + 11, 1'b0, 1'b1, 2);
        expect_pulse(t + 19, 1'b0, 1'b1, 3);
        expect_pulse(t + 27, 1'b0, 1'b1, 4);
        expect_pulse(t + 35, 1'b0, 1'b1, 5);
        wait_n(5);
        check("run_active_on", int'(run_active), 1);
        wait_n(9);
        btn_step = 1'b1;
        wait_n(8);
        btn_step = 1'b0;
        wait_n(18);
        sw_run = 1'b0;
        wait_n(2);
        check("run_active_before_exit", int'(run_active), 1);
        wait_n(1);
        check("run_active_after_exit", int'(run_active), 0);
        wait_n(20);

        // 4: reset press coinciding with a divider tick during run
        t = cyc;
        sw_run = 1'b1;
        expect_pulse(t + 11, 1'b0, 1'b1, 6);
        expect_pulse(t + 21, 1'b1, 1'b0, 0);
        expect_pulse(t + 31, 1'b0, 1'b1, 1);
        expect_pulse(t + 39, 1'b0, 1'b1, 2);
        wait_n(11);
        btn_reset = 1'b1;
        rexp = '{0, 1, 1, 1, 0};
        wait_n(7);
        for (int i = 0; i < 5; i++) begin
            check("cpu_reset_hold", int'(cpu_reset), rexp[i]);
            wait_n(1);
        end
        btn_reset = 1'b0;
        wait_n(19);
        sw_run = 1'b0;
        wait_n(25);

        // 5: simultaneous step and reset -> reset only; then 17 steps wrap the count
        t = cyc;
        btn_step = 1'b1;
        btn_reset = 1'b1;
        expect_pulse(t + 10, 1'b1, 1'b0, 0);
        wait_n(8);
        btn_step = 1'b0;
        btn_reset = 1'b0;
        wait_n(20);
        for (int k = 0; k < 17; k++) begin
            btn_step = 1'b1;
            expect_pulse(cyc + 8, 1'b0, 1'b0, (k + 1) % 16);
            wait_n(6);
            btn_step = 1'b0;
            wait_n(8);
        end
        wait_n(10);
        check("count_wrapped", int'(step_count), 1);

        // 6: block reset during the CPU reset hold
        btn_reset = 1'b1;
        wait_n(9);
        check("hold_before_block_reset", int'(cpu_reset), 1);
        reset = 1'b1;
        btn_reset = 1'b0;
        wait_n(1);
        check("blk_rst_cpu_reset", int'(cpu_reset), 0);
        check("blk_rst_cpu_step", int'(cpu_step), 0);
        check("blk_rst_run_active", int'(run_active), 0);
        check("blk_rst_step_count", int'(step_count), 0);
        check("blk_rst_state_idle", int'(dut.r_state == S_IDLE), 1);
        wait_n(2);
        reset = 1'b0;
        wait_n(20);

        check("pending_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
